// File: rtl/tagged_flux_fifo.sv
// Per-flux tagged FIFO with one muxed read bus and per-flux flags.
// Optional sticky overflow/underflow flags when TAGGED_FIFO_ERR_EN is defined.
module tagged_flux_fifo #(
  parameter int DATA_WIDTH = 18,
  parameter int FLUX       = 2,
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic [FLUX-1:0]  full,
  input  logic [FLUX-1:0]  read,
  output logic [FLUX-1:0]  empty,
  output logic [WIDTH-1:0] dout
`ifdef TAGGED_FIFO_ERR_EN
  ,
  output logic [FLUX-1:0]  err_ovf,
  output logic [FLUX-1:0]  err_udf
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [FLUX*DEPTH];
  logic [PW-1:0]         wr_ptr [FLUX];
  logic [PW-1:0]         rd_ptr [FLUX];
  logic [CW-1:0]         cnt [FLUX];

  logic [TAG_WIDTH-1:0]  wtag;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wtag_ok;
  logic [TAG_WIDTH-1:0]  sel;
  logic [FLUX-1:0]       rd_one;
  logic [FLUX-1:0]       wr_en;
  logic [FLUX-1:0]       rd_en;
  logic [DATA_WIDTH-1:0] head;

  assign wtag    = din[WIDTH-1:DATA_WIDTH];
  assign wdata   = din[DATA_WIDTH-1:0];
  assign wtag_ok = int'(wtag) < FLUX;
  // Isolate lowest set bit so extra read strobes are ignored.
  assign rd_one  = read & (~read + FLUX'(1));

  always_comb begin
    sel = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (read[i]) sel = TAG_WIDTH'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      empty[i] = (cnt[i] == '0);
      full[i]  = (cnt[i] == CW'(DEPTH));
    end
  end

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      wr_en[i] = write && wtag_ok &&
                 (wtag == TAG_WIDTH'(i)) && !full[i];
      rd_en[i] = rd_one[i] && !empty[i];
    end
  end

  // Empty queues present zero so stale storage never leaks onto dout.
  always_comb begin
    head = mem[{sel, rd_ptr[sel]}];
    if (empty[sel]) head = '0;
    dout = {sel, head};
  end

  always_ff @(posedge clk) begin
    if (!rst && write && wtag_ok && !full[wtag])
      mem[{wtag, wr_ptr[wtag]}] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
        unique case ({wr_en[i], rd_en[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

`ifdef TAGGED_FIFO_ERR_EN
  logic [FLUX-1:0] ovf_hit;

  always_comb begin
    for (int i = 0; i < FLUX; i++)
      ovf_hit[i] = write && wtag_ok &&
                   (wtag == TAG_WIDTH'(i)) && full[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= '0;
      err_udf <= '0;
    end else begin
      err_ovf <= err_ovf | ovf_hit;
      err_udf <= err_udf | (read & empty);
    end
  end
`endif

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// Bench for tagged_flux_fifo: directed plan plus random traffic
// checked each cycle against a queue-based reference.
module tb_tagged_flux_fifo;

  localparam int DW = 18;
  localparam int F  = 2;
  localparam int D  = 8;
  localparam int W  = DW + 1;

  logic         clk = 0;
  logic         rst;
  logic         write;
  logic [W-1:0] din;
  logic [F-1:0] full;
  logic [F-1:0] read;
  logic [F-1:0] empty;
  logic [W-1:0] dout;
`ifdef TAGGED_FIFO_ERR_EN
  logic [F-1:0] err_ovf;
  logic [F-1:0] err_udf;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [F][$];
  logic [F-1:0]  m_ovf;
  logic [F-1:0]  m_udf;

  tagged_flux_fifo #(
    .DATA_WIDTH(DW),
    .FLUX(F),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write(write),
    .din(din),
    .full(full),
    .read(read),
    .empty(empty),
    .dout(dout)
`ifdef TAGGED_FIFO_ERR_EN
    ,
    .err_ovf(err_ovf),
    .err_udf(err_udf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r_rst, input logic w,
                       input logic [W-1:0] d,
                       input logic [F-1:0] r);
    logic [F-1:0]  e_empty, e_full;
    logic [W-1:0]  e_dout;
    int            s, t;
    logic          wok, rok;
    rst = r_rst; write = w; din = d; read = r;
    #1;
    s = 0;
    for (int i = F - 1; i >= 0; i--) if (r[i]) s = i;
    for (int i = 0; i < F; i++) begin
      e_empty[i] = (q[i].size() == 0);
      e_full[i]  = (q[i].size() == D);
    end
    e_dout = {s[0], (q[s].size() > 0) ? q[s][0] : {DW{1'b0}}};
    chk("empty", 32'(empty), 32'(e_empty));
    chk("full", 32'(full), 32'(e_full));
    chk("dout", 32'(dout), 32'(e_dout));
`ifdef TAGGED_FIFO_ERR_EN
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_udf", 32'(err_udf), 32'(m_udf));
`endif
    @(posedge clk);
    if (r_rst) begin
      for (int i = 0; i < F; i++) q[i].delete();
      m_ovf = '0;
      m_udf = '0;
    end else begin
      t   = int'(d[W-1]);
      wok = w && (q[t].size() < D);
      rok = (r != 0) && (q[s].size() > 0);
      if (w && q[t].size() == D) m_ovf[t] = 1'b1;
      for (int i = 0; i < F; i++)
        if (r[i] && q[i].size() == 0) m_udf[i] = 1'b1;
      if (rok) void'(q[s].pop_front());
      if (wok) q[t].push_back(d[DW-1:0]);
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] word(input int t, input int v);
    word = {t[0], v[DW-1:0]};
  endfunction

  initial begin
    m_ovf = '0;
    m_udf = '0;
    rst = 1; write = 0; din = '0; read = '0;
    @(posedge clk);
    @(negedge clk);
    cycle(1, 0, '0, '0);

    // single word round trip on flux 1
    cycle(0, 1, word(1, 'hABC), 2'b00);
    cycle(0, 0, '0, 2'b10);
    cycle(0, 0, '0, 2'b00);

    // fill flux 0, overflow attempt, drain
    for (int i = 0; i < 8; i++) cycle(0, 1, word(0, i), 2'b00);
    cycle(0, 1, word(0, 'h3FFFF), 2'b00);
    for (int i = 0; i < 8; i++) cycle(0, 0, '0, 2'b01);
    cycle(0, 0, '0, 2'b01);

    // full flux 0 with simultaneous write and read
    for (int i = 0; i < 8; i++) cycle(0, 1, word(0, 16 + i), 2'b00);
    cycle(0, 1, word(0, 'h1234), 2'b01);
    chk("cnt_after_fullrw", 32'(q[0].size()), 32'd7);
    cycle(0, 0, '0, 2'b00);

    // flux 1 steady-state at depth 3, pointers wrap
    for (int i = 0; i < 3; i++) cycle(0, 1, word(1, 100 + i), 2'b00);
    for (int i = 0; i < 20; i++)
      cycle(0, 1, word(1, $urandom_range(0, 'h3FFFF)), 2'b10);
    cycle(0, 0, '0, 2'b00);

    // both strobes set: only flux 0 pops
    cycle(0, 0, '0, 2'b11);
    cycle(0, 0, '0, 2'b11);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(0, 1'($urandom_range(0, 1)),
            word($urandom_range(0, 1), $urandom_range(0, 'h3FFFF)),
            2'($urandom_range(0, 3)));

    // reset with both fluxes holding data
    cycle(0, 1, word(0, 7), 2'b00);
    cycle(0, 1, word(1, 9), 2'b00);
    cycle(0, 1, word(1, 5), 2'b10);
    cycle(1, 0, '0, 2'b00);
    cycle(0, 0, '0, 2'b00);
    cycle(0, 0, '0, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
